// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-side arbiter: burst FSM state
// encoding and a width helper for requester indices.
package fifo_wr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    // Bits needed to index n requesters; never returns less than 1.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: finds the first set request bit
// searching upward from rr_last_i + 1 with wrap. Shared with the read side.
module fifo_wr_arbiter_rr_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]          req_i,
    input  logic [clog2(N)-1:0]   rr_last_i,
    output logic [clog2(N)-1:0]   sel_o,
    output logic                  valid_o
);

    localparam int W = clog2(N);

    // Scan from farthest to nearest so the nearest set bit after rr_last wins.
    always_comb begin
        logic [W-1:0] idx;
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        sel_o = '0;
        idx   = '0;
        for (int i = N; i >= 1; i--) begin
            idx = W'((int'(rr_last_i) + i) % N);
            if (req_i[idx]) sel_o = idx;
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-side scheduler sharing one FIFO write port between NREQ requesters
// with round-robin burst grants. Optional macro FIFO_ARB_PRIO_EN makes
// requester 0 strict high priority at arbitration time.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int DATASIZE  = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                     wr_clk,
    input  logic                     wr_rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DATASIZE-1:0] req_data,
    input  logic [NREQ-1:0]          req_last,
    input  logic                     fifo_full,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          ack,
    output logic                     fifo_wr_en,
    output logic [DATASIZE-1:0]      fifo_wr_data,
    output logic [clog2(NREQ)-1:0]   active_id,
    output logic                     busy
);

    localparam int         AW        = clog2(NREQ);
    localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

    state_e          state_q;
    logic [NREQ-1:0] gnt_q;
    logic [AW-1:0]   active_id_q;
    logic [AW-1:0]   rr_last_q;
    logic [7:0]      beat_cnt_q;

    logic [AW-1:0]   rr_sel;
    logic            rr_valid;
    logic [AW-1:0]   pick_sel;
    logic            pick_upd_rr;
    logic            accept;
    logic            end_burst;

    fifo_wr_arbiter_rr_pick #(.N(NREQ)) u_rr_pick (
        .req_i     (req),
        .rr_last_i (rr_last_q),
        .sel_o     (rr_sel),
        .valid_o   (rr_valid)
    );

    // Choose the next winner; with priority enabled requester 0 bypasses the rotation.
    always_comb begin
`ifdef FIFO_ARB_PRIO_EN
        pick_sel    = req[0] ? '0 : rr_sel;
        pick_upd_rr = ~req[0];
`else
        pick_sel    = rr_sel;
        pick_upd_rr = 1'b1;
`endif
    end

    assign busy      = (state_q == ST_BURST);
    assign accept    = busy & req[active_id_q] & ~fifo_full;
    // Withdrawal ends the burst without a beat; last flag or beat limit end it on a beat.
    assign end_burst = ~req[active_id_q]
                     | (accept & (req_last[active_id_q] | (beat_cnt_q == LAST_BEAT)));

    // Burst FSM: arbitration in IDLE, beat counting and release in BURST.
    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            active_id_q <= '0;
            rr_last_q   <= AW'(NREQ - 1);
            beat_cnt_q  <= '0;
        end else begin
            // NOTE: non-blocking updates let every register here see pre-edge values of the others.
            case (state_q)
                ST_IDLE: begin
                    if (rr_valid) begin
                        state_q     <= ST_BURST;
                        gnt_q       <= NREQ'(1) << pick_sel;
                        active_id_q <= pick_sel;
                        beat_cnt_q  <= '0;
                        if (pick_upd_rr) rr_last_q <= pick_sel;
                    end
                end
                ST_BURST: begin
                    if (end_burst) begin
                        state_q    <= ST_IDLE;
                        gnt_q      <= '0;
                        beat_cnt_q <= '0;
                    end else if (accept) begin
                        beat_cnt_q <= beat_cnt_q + 8'd1;
                    end
                end
            endcase
        end
    end

    assign gnt          = gnt_q;
    assign active_id    = active_id_q;
    assign fifo_wr_en   = accept;
    assign ack          = accept ? gnt_q : '0;
    assign fifo_wr_data = busy ? req_data[int'(active_id_q)*DATASIZE +: DATASIZE] : '0;

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Write-side scheduler for the asynchronous FIFO. Shares the single FIFO write port (wr_en/wr_data) between NREQ requesters in the wr_clk domain.
- Round-robin burst arbitration. A grant is held for one burst, which ends on the requester's last flag, on MAX_BURST beats, or on request withdrawal.
- The FIFO's o_fifo_full (already in wr_clk domain) back-pressures the granted requester.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DATASIZE, 8, data width, matches FIFO DATASIZE.
- MAX_BURST, 16, maximum beats per grant (1..255).

Ports:
- wr_clk  input  1  write-domain clock, same clock as FIFO write side.
- wr_rst  input  1  asynchronous active-high reset.
- req  input  NREQ  per-requester request; a level held while data is valid.
- req_data  input  NREQ*DATASIZE  packed data; requester i occupies bits [i*DATASIZE +: DATASIZE].
- req_last  input  NREQ  marks the final beat of a requester's burst.
- fifo_full  input  1  from FIFO o_fifo_full.
- gnt  output  NREQ  one-hot registered grant.
- ack  output  NREQ  beat accepted this cycle, one-hot.
- fifo_wr_en  output  1  drives FIFO wr_en.
- fifo_wr_data  output  DATASIZE  drives FIFO wr_data.
- active_id  output  clog2(NREQ)  index of the granted requester.
- busy  output  1  high in BURST state.

Behaviour:
- Reset (async, wr_rst=1): state=IDLE; gnt=0, ack=0, fifo_wr_en=0, fifo_wr_data=0, active_id=0, busy=0; beat_cnt=0; rr_last=NREQ-1, so requester 0 wins first. Reset mid-burst aborts the burst immediately; no partial-state recovery.
- States: IDLE, BURST.
- IDLE:
  - If any req, select the first set bit searching from rr_last+1 upward, with modulo-NREQ wrap.
  - On the next edge: gnt=onehot(sel), active_id=sel, rr_last=sel, beat_cnt=0, state=BURST.
  - No req: stay in IDLE. There is always one IDLE cycle between bursts.
- BURST (combinational outputs from registered state):
  - accept = req[active_id] & ~fifo_full.
  - fifo_wr_en = accept; ack[active_id] = accept; fifo_wr_data = req_data slice of active_id whenever busy, else 0.
  - Latency from req to first write is 2 edges: arbitration edge, then the write edge.
- Burst termination (evaluated at the edge):
  - accept & req_last[active_id] -> IDLE.
  - accept & beat_cnt==MAX_BURST-1 -> IDLE (forced release, even without last).
  - ~req[active_id] -> IDLE (withdrawal; no beat written that cycle).
  - Otherwise on accept, beat_cnt+1.
  - On transition to IDLE, gnt clears the same edge.
- fifo_full: accept=0 and beat_cnt holds. Grant is retained indefinitely while full; no timeout.
- Non-granted requesters never see ack. Their req/data are ignored; they must hold req.
- req_last on a non-accepted cycle has no effect.
- beat_cnt is 8 bits, compared against MAX_BURST-1, never wraps.
- Simultaneous termination conditions collapse to a single IDLE transition.

Optional Feature:
- Macro FIFO_ARB_PRIO_EN.
- Defined: requester 0 is strict high priority. In IDLE, req[0] wins regardless of rr_last, and rr_last is not updated when 0 wins. An active burst is never pre-empted.
- Undefined: pure round-robin as described above.

Decomposition:
- Shared package/include: state encoding constants (ST_IDLE=1'b0, ST_BURST=1'b1) and a clog2 function for active_id width.
- One sub-module, rr_pick: combinational round-robin selector (req, rr_last -> sel, valid). It is reused by the read-side scheduler later.

Test Plan:
- Reset then req=4'b0110 held, each burst of 3 beats with last on beat 3 -> grants 1 then 2 alternately; 3 fifo_wr_en pulses per grant; one IDLE gap between grants.
- req[3] held, never sets last, MAX_BURST=16 -> exactly 16 writes, then release; re-grant after 1 IDLE cycle.
- fifo_full=1 for 5 cycles mid-burst at beat 4 -> fifo_wr_en=0, ack=0, gnt held, beat_cnt stays 4; resumes at beat 5 when full drops.
- Requester 2 drops req after 2 beats -> burst ends with no extra write; next requester per round-robin order granted.
- wr_rst asserted mid-burst at beat 7 -> all outputs 0 asynchronously; after release with req=4'b1111, requester 0 granted first.
- FIFO_ARB_PRIO_EN defined, req=4'b1111 continuous with 1-beat bursts -> grant sequence 0,0,0,...; with the macro undefined -> 0,1,2,3,0.
